// File: rtl/countdown_timer.sv
// countdown_timer: loadable two-digit BCD countdown with prescaled tick and timeout pulse
module countdown_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       CLKT,
  input  logic       R,
  input  logic       START,
  input  logic       CLEAR,
  input  logic       PAUSE,
  input  logic [3:0] LOAD_TENS,
  input  logic [3:0] LOAD_UNITS,
  output logic [3:0] TENS,
  output logic [3:0] UNITS,
  output logic       BUSY,
  output logic       TICK,
  output logic       TIMEOUT
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [3:0] tens, units, tens_n, units_n, lt, lu;
  logic tick, tick_n, timeout, timeout_n;
  assign lt = LOAD_TENS > 4'd9 ? 4'd9 : LOAD_TENS;
  assign lu = LOAD_UNITS > 4'd9 ? 4'd9 : LOAD_UNITS;
  always_ff @(posedge CLKT) begin
    if (R) begin
      state <= IDLE;
      pre <= '0;
      tens <= 4'd0;
      units <= 4'd0;
      tick <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      pre <= pre_n;
      tens <= tens_n;
      units <= units_n;
      tick <= tick_n;
      timeout <= timeout_n;
    end
  end
  always_comb begin
    state_n = state;
    pre_n = pre;
    tens_n = tens;
    units_n = units;
    tick_n = 1'b0;
    timeout_n = 1'b0;
    if (CLEAR) begin
      state_n = IDLE;
      pre_n = '0;
    end else if (START) begin
      tens_n = lt;
      units_n = lu;
      pre_n = '0;
      state_n = (lt == 4'd0 && lu == 4'd0) ? IDLE : RUN;
      timeout_n = lt == 4'd0 && lu == 4'd0;
    end else if (state != IDLE) begin
      state_n = PAUSE ? HOLD : RUN;
      if (!PAUSE) begin
        pre_n = pre == TERM ? '0 : pre + 1'b1;
        if (pre == TERM) begin
          tick_n = 1'b1;
          units_n = units != 4'd0 ? units - 4'd1 : 4'd9;
          tens_n = units != 4'd0 ? tens : tens - 4'd1;
          timeout_n = tens == 4'd0 && units == 4'd1;
          state_n = timeout_n ? IDLE : RUN;
        end
      end
    end
  end
  assign TENS = tens;
  assign UNITS = units;
  assign BUSY = state != IDLE;
  assign TICK = tick;
  assign TIMEOUT = timeout;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: randomized and directed check of countdown_timer against a decimal reference model
module tb_countdown_timer;
  localparam int TD = 4;
  logic CLKT = 1'b0;
  logic R = 1'b0, START = 1'b0, CLEAR = 1'b0, PAUSE = 1'b0;
  logic [3:0] LOAD_TENS = 4'd0, LOAD_UNITS = 4'd0;
  logic [3:0] TENS, UNITS;
  logic BUSY, TICK, TIMEOUT;
  int checks = 0, failures = 0;
  int m_n = 0, m_e = 0, m_busy = 0, m_tick = 0, m_to = 0;
  int n, ticks;
  logic pz = 1'b0;
  countdown_timer #(.TICK_DIV(TD)) dut (
    .CLKT(CLKT), .R(R), .START(START), .CLEAR(CLEAR), .PAUSE(PAUSE),
    .LOAD_TENS(LOAD_TENS), .LOAD_UNITS(LOAD_UNITS),
    .TENS(TENS), .UNITS(UNITS), .BUSY(BUSY), .TICK(TICK), .TIMEOUT(TIMEOUT)
  );
  always #5 CLKT = ~CLKT;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_edge();
    int a, b;
    m_tick = 0;
    m_to = 0;
    if (R) begin
      m_n = 0; m_e = 0; m_busy = 0;
    end else if (CLEAR) begin
      m_busy = 0; m_e = 0;
    end else if (START) begin
      a = LOAD_TENS > 9 ? 9 : int'(LOAD_TENS);
      b = LOAD_UNITS > 9 ? 9 : int'(LOAD_UNITS);
      m_n = a * 10 + b;
      m_e = 0;
      m_busy = m_n != 0;
      m_to = m_n == 0;
    end else if (m_busy != 0 && !PAUSE) begin
      if (m_e == TD - 1) begin
        m_e = 0;
        m_n--;
        m_tick = 1;
        if (m_n == 0) begin
          m_to = 1;
          m_busy = 0;
        end
      end else m_e++;
    end
  endtask
  task automatic step(input logic r, input logic st, input logic cl, input logic pa,
                      input logic [3:0] lt, input logic [3:0] lu);
    R = r; START = st; CLEAR = cl; PAUSE = pa; LOAD_TENS = lt; LOAD_UNITS = lu;
    @(posedge CLKT);
    model_edge();
    #1;
    chk("tens", TENS, m_n / 10);
    chk("units", UNITS, m_n % 10);
    chk("busy", BUSY, m_busy);
    chk("tick", TICK, m_tick);
    chk("timeout", TIMEOUT, m_to);
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 4'd0, 4'd0);
  endtask
  task automatic wait_to(input int lim, output int cnt, output int tk);
    cnt = -1;
    tk = 0;
    for (int i = 1; i <= lim; i++) begin
      step(0, 0, 0, 0, 4'd0, 4'd0);
      tk += int'(TICK);
      if (TIMEOUT) begin
        cnt = i;
        return;
      end
    end
  endtask
  initial begin
    step(1, 0, 0, 0, 4'd0, 4'd0);
    chk("rst_busy", BUSY, 0);
    step(0, 1, 0, 0, 4'd3, 4'd5);
    idle(6);
    step(1, 0, 0, 0, 4'd0, 4'd0);
    step(1, 0, 0, 0, 4'd0, 4'd0);
    chk("rst_tens", TENS, 0);
    chk("rst_units", UNITS, 0);
    idle(10);
    step(0, 1, 0, 0, 4'd0, 4'd3);
    wait_to(20, n, ticks);
    chk("full_to_edge", n, 12);
    chk("full_ticks", ticks, 3);
    chk("full_busy", BUSY, 0);
    idle(6);
    step(0, 1, 0, 0, 4'd1, 4'd0);
    idle(4);
    chk("borrow_tens", TENS, 0);
    chk("borrow_units", UNITS, 9);
    step(0, 1, 0, 0, 4'd1, 4'd10);
    chk("clamp_tens", TENS, 1);
    chk("clamp_units", UNITS, 9);
    step(0, 1, 0, 0, 4'd0, 4'd2);
    idle(2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 4'd0, 4'd0);
    chk("hold_busy", BUSY, 1);
    chk("hold_units", UNITS, 2);
    wait_to(20, n, ticks);
    chk("pause_to_edge", n + 7, 13);
    step(0, 1, 0, 0, 4'd0, 4'd5);
    idle(5);
    step(0, 1, 0, 0, 4'd0, 4'd2);
    wait_to(20, n, ticks);
    chk("restart_to_edge", n, 8);
    step(0, 1, 0, 0, 4'd0, 4'd1);
    idle(3);
    step(0, 0, 1, 0, 4'd0, 4'd0);
    chk("clr_timeout", TIMEOUT, 0);
    chk("clr_units", UNITS, 1);
    chk("clr_busy", BUSY, 0);
    idle(8);
    step(0, 1, 0, 0, 4'd0, 4'd0);
    chk("zero_timeout", TIMEOUT, 1);
    chk("zero_busy", BUSY, 0);
    chk("zero_tick", TICK, 0);
    idle(2);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) pz = ~pz;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 119) == 0, pz,
           4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable two-digit BCD countdown timer for the GENIUS game datapath. It is the deadline-enforcing counterpart to the elapsed-time up-counter: it is loaded with a response window of 00–99 ticks, counts down once per prescaled tick, and emits a one-cycle `TIMEOUT` pulse when it reaches 00. The game controller uses it to abort a player turn. `TENS`/`UNITS` drive the seven-segment decoders directly.

## Interface
- `TICK_DIV`, default 50_000_000: CLKT cycles per countdown tick; legal range ≥ 2. The prescaler width is `$clog2(TICK_DIV)`.
- `CLKT` input 1: system clock; all logic on its rising edge.
- `R` input 1: reset, synchronous, active-high.
- `START` input 1: load pulse; samples `LOAD_TENS`/`LOAD_UNITS`.
- `CLEAR` input 1: abort; returns to IDLE without `TIMEOUT`.
- `PAUSE` input 1: level; freezes the countdown while high.
- `LOAD_TENS` input 4: BCD tens digit of the window.
- `LOAD_UNITS` input 4: BCD units digit of the window.
- `TENS` output 4: current tens digit.
- `UNITS` output 4: current units digit.
- `BUSY` output 1: high in RUN or HOLD.
- `TICK` output 1: one-cycle pulse per decrement.
- `TIMEOUT` output 1: one-cycle pulse on expiry.

## Operation
- States and encodings:
  - IDLE: BUSY=0.
  - RUN: BUSY=1, prescaler advancing.
  - HOLD: BUSY=1, prescaler and digits frozen.
- Priority, every edge: `R` > `CLEAR` > `START` > `PAUSE` > normal count.
- Reset (`R`=1 at an edge):
  - State goes to IDLE.
  - TENS=0, UNITS=0, prescaler=0.
  - BUSY, TICK and TIMEOUT all 0.
- `START` in any state:
  - Loads the digits and clears the prescaler.
  - Any digit > 9 is clamped to 9.
  - A nonzero load enters RUN.
  - A load of 00 stays in or enters IDLE and pulses TIMEOUT.
  - A START during RUN or HOLD is a restart with the new value; no TIMEOUT is issued for the aborted window.
- `CLEAR`:
  - State goes to IDLE and the prescaler to 0.
  - Digits hold their last value (for display).
  - No TICK or TIMEOUT.
- RUN behaviour:
  - If PAUSE=1, go to HOLD; nothing changes.
  - Otherwise, if prescaler == TICK_DIV−1: prescaler goes to 0, the BCD count decrements, and TICK pulses. If not, the prescaler increments.
- HOLD behaviour: when PAUSE=0, return to RUN; the prescaler resumes from its held value, so no tick time is lost or gained.
- BCD decrement:
  - If UNITS≠0, UNITS−1.
  - Else UNITS goes to 9 and TENS−1.
  - The count never goes below 00, so there is no wrap from 00 to 99.
- Expiry: a decrement that produces 00 also pulses TIMEOUT and moves the state to IDLE at that same edge. TICK and TIMEOUT are both high in that cycle.
- IDLE ignores PAUSE. Digits hold their value.

## Timing
- All outputs are registered. A pulse asserted "at edge k" is high for exactly the cycle following edge k.
- START sampled at edge k:
  - Digits show the loaded value and BUSY=1 from edge k.
  - The first decrement happens at edge k+TICK_DIV.
  - A load of N (decimal value) with no pause gives TIMEOUT at edge k+N·TICK_DIV.
- PAUSE high for P edges while in RUN delays TIMEOUT by exactly P cycles.
- START with 00 at edge k: TIMEOUT at edge k, BUSY stays 0.
- Simultaneous events at one edge:
  - START and a tick-terminal prescaler: the load wins, no TICK.
  - CLEAR and an expiry tick: CLEAR wins, no TIMEOUT.
  - R with anything: reset wins.
- Reset mid-count: outputs show their reset values at the next edge, with no residual pulses.
- TICK and TIMEOUT are never high for two consecutive cycles unless START re-expires them with a 00 load.

## Test plan
All scenarios use TICK_DIV=4.
- **Reset:** hold R for 2 edges while counting from 35 → TENS=0, UNITS=0, BUSY=0, and no TICK or TIMEOUT afterwards.
- **Full countdown:** START with 03 at edge k → TICK at edges k+4, k+8 and k+12; UNITS reads 2, then 1, then 0; TIMEOUT and BUSY→0 at edge k+12; exactly one TIMEOUT.
- **Borrow:** START with 10 → after 4 edges the display reads 09. START with 1A → the display reads 19 (clamp).
- **Pause:** START with 02, PAUSE high for 5 cycles in the middle of the first tick → state is HOLD with digits frozen; TIMEOUT arrives at k+13 instead of k+8.
- **Restart and abort:**
  - START with 05, then START with 02 at k+6 → TIMEOUT at k+14 only.
  - CLEAR on the expiry edge → no TIMEOUT, digits stay at 01, BUSY=0.
- **Zero load:** START with 00 → a single TIMEOUT pulse on the next cycle, BUSY stays 0, and no TICK.
